// File: rtl/snoopy_vertical_fsm.sv
// rtl/snoopy_vertical_fsm.sv - vertical jump/rise/fall/land controller for Snoopy
module snoopy_vertical_fsm #(
    parameter int GROUND_Y   = 100,
    parameter int MIN_Y      = 0,
    parameter int JUMP_SPEED = 6,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       input_jump,
    output logic [7:0] snoopy_y,
    output logic       airborne,
    output logic       landed
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        SPARE  = 2'd3
    } state_t;

    localparam logic [7:0] GROUND_8 = 8'(GROUND_Y);
    localparam logic [7:0] MIN_8    = 8'(MIN_Y);
    localparam logic [8:0] GROUND_9 = 9'(GROUND_Y);
    localparam logic [8:0] MIN_9    = 9'(MIN_Y);
    localparam logic [7:0] JUMP_8   = 8'(JUMP_SPEED);
    localparam logic [8:0] GRAV_9   = 9'(GRAVITY);
    localparam logic [8:0] MAXF_9   = 9'(MAX_FALL);

    state_t     state, state_d;
    logic [7:0] y_q, y_d;
    logic [7:0] vel_q, vel_d;
    logic       armed_q, armed_d;
    logic       landed_q, land_evt;
    logic       on_ground;

    logic [8:0] rise_floor;
    logic [7:0] rise_t;
    logic [8:0] rise_vn;
    logic [8:0] fall_sum;
    logic [8:0] fall_vn;
    logic [8:0] fall_t;

    // The spare encoding behaves as GROUND everywhere
    assign on_ground = (state != RISE) && (state != FALL);

    // Ceiling test is y <= MIN_Y + vel, so the subtraction below is only used when it cannot wrap
    assign rise_floor = MIN_9 + {1'b0, vel_q};
    assign rise_t     = y_q - vel_q;
    assign rise_vn    = ({1'b0, vel_q} > GRAV_9) ? ({1'b0, vel_q} - GRAV_9) : 9'd0;
    assign fall_sum   = {1'b0, vel_q} + GRAV_9;
    assign fall_vn    = (fall_sum > MAXF_9) ? MAXF_9 : fall_sum;
    assign fall_t     = {1'b0, y_q} + fall_vn;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= GROUND;
            y_q      <= GROUND_8;
            vel_q    <= 8'd0;
            armed_q  <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state    <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            armed_q  <= armed_d;
            landed_q <= land_evt;
        end
    end

    always_comb begin
        state_d  = state;
        y_d      = y_q;
        vel_d    = vel_q;
        armed_d  = armed_q;
        land_evt = 1'b0;

        if (on_ground && !input_jump) begin
            armed_d = 1'b1;
        end

        case (state)
            GROUND: begin
                if (frame_tick && input_jump && armed_q) begin
                    state_d = RISE;
                    vel_d   = JUMP_8;
                    armed_d = 1'b0;
                end
            end
            RISE: begin
                if (frame_tick) begin
                    if ({1'b0, y_q} <= rise_floor) begin
                        y_d     = MIN_8;
                        vel_d   = 8'd0;
                        state_d = FALL;
                    end else begin
                        y_d = rise_t;
                        if (rise_vn == 9'd0) begin
                            vel_d   = 8'd0;
                            state_d = FALL;
                        end else begin
                            vel_d = rise_vn[7:0];
                        end
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (fall_t >= GROUND_9) begin
                        y_d      = GROUND_8;
                        vel_d    = 8'd0;
                        state_d  = GROUND;
                        land_evt = 1'b1;
                    end else begin
                        y_d   = fall_t[7:0];
                        vel_d = fall_vn[7:0];
                    end
                end
            end
            default: begin
                state_d = GROUND;
                y_d     = GROUND_8;
                vel_d   = 8'd0;
            end
        endcase
    end

    assign snoopy_y = y_q;
    assign airborne = !on_ground;
    assign landed   = landed_q;

endmodule

// File: tb/tb_snoopy_vertical_fsm.sv
// tb/tb_snoopy_vertical_fsm.sv - bench for snoopy_vertical_fsm with three parameterisations
module tb_snoopy_vertical_fsm;

    logic clock = 1'b0;
    logic reset, frame_tick, input_jump;
    logic [7:0] y0, y1, y2;
    logic a0, a1, a2, l0, l1, l2;

    always #5 clock = ~clock;

    snoopy_vertical_fsm u_def (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(input_jump),
        .snoopy_y(y0), .airborne(a0), .landed(l0)
    );
    snoopy_vertical_fsm #(.MIN_Y(85)) u_min (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(input_jump),
        .snoopy_y(y1), .airborne(a1), .landed(l1)
    );
    snoopy_vertical_fsm #(.MAX_FALL(2)) u_fall (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .input_jump(input_jump),
        .snoopy_y(y2), .airborne(a2), .landed(l2)
    );

    int checks = 0;
    int errors = 0;

    localparam int G  = 100;
    localparam int JS = 6;
    localparam int GR = 1;
    int p_min[3]  = '{0, 85, 0};
    int p_maxf[3] = '{6, 6, 2};

    // Reference: signed velocity (negative = upward), in_air flag
    int m_y[3]    = '{100, 100, 100};
    int m_v[3]    = '{0, 0, 0};
    bit m_air[3]  = '{0, 0, 0};
    bit m_arm[3]  = '{0, 0, 0};
    bit m_land[3] = '{0, 0, 0};

    task automatic model_step(input bit r, input bit t, input bit j);
        for (int i = 0; i < 3; i++) begin
            bit was_air;
            bit arm_n;
            int nv;
            was_air = m_air[i];
            arm_n   = m_arm[i];
            if (r) begin
                m_y[i] = G; m_v[i] = 0; m_air[i] = 0; m_arm[i] = 0; m_land[i] = 0;
            end else begin
                m_land[i] = 0;
                if (!was_air && !j) arm_n = 1;
                if (t) begin
                    if (!was_air) begin
                        if (j && m_arm[i]) begin
                            m_air[i] = 1; m_v[i] = -JS; arm_n = 0;
                        end
                    end else if (m_v[i] < 0) begin
                        if (m_y[i] + m_v[i] <= p_min[i]) begin
                            m_y[i] = p_min[i]; m_v[i] = 0;
                        end else begin
                            m_y[i] = m_y[i] + m_v[i];
                            m_v[i] = (m_v[i] + GR > 0) ? 0 : m_v[i] + GR;
                        end
                    end else begin
                        nv = m_v[i] + GR;
                        if (nv > p_maxf[i]) nv = p_maxf[i];
                        m_v[i] = nv;
                        m_y[i] = m_y[i] + nv;
                        if (m_y[i] >= G) begin
                            m_y[i] = G; m_v[i] = 0; m_air[i] = 0; m_land[i] = 1;
                        end
                    end
                end
                m_arm[i] = arm_n;
            end
        end
    endtask

    function automatic logic [29:0] exp_vec();
        return {8'(m_y[0]), m_air[0], m_land[0],
                8'(m_y[1]), m_air[1], m_land[1],
                8'(m_y[2]), m_air[2], m_land[2]};
    endfunction

    wire [29:0] act_vec = {y0, a0, l0, y1, a1, l1, y2, a2, l2};

    task automatic cycle(input bit r, input bit t, input bit j);
        reset = r; frame_tick = t; input_jump = j;
        @(posedge clock);
        model_step(r, t, j);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        checks++;
        if (act_vec !== {8'd100, 2'b00, 8'd100, 2'b00, 8'd100, 2'b00}) begin
            errors++; $display("FAIL reset_state actual=%h required=%h", act_vec,
                               {8'd100, 2'b00, 8'd100, 2'b00, 8'd100, 2'b00});
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0);
            checks++;
            if (act_vec !== exp_vec() || y0 !== 8'd100 || l0 !== 1'b0 || a0 !== 1'b0) begin
                errors++; $display("FAIL idle_tick%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_jump();
        int exp_def[18]  = '{100, 94, 89, 85, 82, 80, 79, 80, 82, 85, 89, 94, 100, 100, 100, 100, 100, 100};
        int exp_min[18]  = '{100, 94, 89, 85, 86, 88, 91, 95, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        int exp_fall[18] = '{100, 94, 89, 85, 82, 80, 79, 80, 82, 84, 86, 88, 90, 92, 94, 96, 98, 100};
        int pulses = 0;
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        checks++;
        if (a0 !== 1'b1 || y0 !== 8'd100) begin
            errors++; $display("FAIL jump_accept actual=y%0d/a%0d required=y100/a1", y0, a0);
        end
        for (int k = 1; k <= 17; k++) begin
            cycle(0, 1, 0);
            pulses += l0;
            checks++;
            if (y0 !== 8'(exp_def[k]) || y1 !== 8'(exp_min[k]) || y2 !== 8'(exp_fall[k])) begin
                errors++; $display("FAIL jump_y_tick%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                                   k, y0, y1, y2, exp_def[k], exp_min[k], exp_fall[k]);
            end
            checks++;
            if (a0 !== (k < 12) || act_vec !== exp_vec()) begin
                errors++; $display("FAIL jump_model_tick%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
            if (k == 12) begin
                checks++;
                if (l0 !== 1'b1) begin
                    errors++; $display("FAIL landed_pulse actual=%0d required=1", l0);
                end
            end
            cycle(0, 0, 0);
            pulses += l0;
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL jump_idle%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL landed_count actual=%0d required=1", pulses);
        end
    endtask

    task automatic test_hold();
        cycle(0, 0, 0);
        for (int k = 0; k < 25; k++) begin
            cycle(0, 1, 1);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL hold_tick%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
        end
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++; $display("FAIL hold_no_relaunch actual=%b required=000", {a0, a1, a2});
        end
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        checks++;
        if ({a0, a1, a2} !== 3'b111 || act_vec !== exp_vec()) begin
            errors++; $display("FAIL hold_rejump actual=%h required=%h", act_vec, exp_vec());
        end
        for (int k = 0; k < 20; k++) cycle(0, 1, 0);
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1);
        checks++;
        if (y0 !== 8'd82 || a0 !== 1'b1) begin
            errors++; $display("FAIL mid_pre_reset actual=y%0d/a%0d required=y82/a1", y0, a0);
        end
        cycle(1, 0, 1);
        checks++;
        if (act_vec !== {8'd100, 2'b00, 8'd100, 2'b00, 8'd100, 2'b00} || act_vec !== exp_vec()) begin
            errors++; $display("FAIL mid_reset actual=%h required=%h", act_vec, exp_vec());
        end
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 1);
            checks++;
            if (a0 !== 1'b0 || l0 !== 1'b0 || act_vec !== exp_vec()) begin
                errors++; $display("FAIL mid_held%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
        end
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        checks++;
        if (a0 !== 1'b1 || act_vec !== exp_vec()) begin
            errors++; $display("FAIL mid_relaunch actual=%h required=%h", act_vec, exp_vec());
        end
        for (int k = 0; k < 20; k++) cycle(0, 1, 0);
    endtask

    task automatic test_random();
        bit j = 0;
        bit r, t;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9) == 0) j = ~j;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 2) == 0);
            cycle(r, t, j);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d actual=%h required=%h", k, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; input_jump = 1'b0;
        test_reset();
        test_jump();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
